// File: rtl/hazard_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    // Width of the internal wait-state and branch-flush sequencing counters.
    localparam int unsigned SEQ_CNT_W = 8;

    // Stall/flush request bundle for the four segment registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug statistics; clocked on the pipeline negedge.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (inc && (q != {W{1'b1}})) begin
            q_d = q + W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stall, branch flush,
// data-memory wait states with timeout, and saturating stall/flush statistics.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned BR_FLUSH_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [SEQ_CNT_W-1:0] TIMEOUT_C = SEQ_CNT_W'(MEM_TIMEOUT);
    localparam logic [SEQ_CNT_W-1:0] BR_CYC_C  = SEQ_CNT_W'(BR_FLUSH_CYC);

    hz_state_t            state_q, state_d;
    logic [SEQ_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [SEQ_CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic                 mem_err_q, mem_err_d;

    hz_ctrl_t ctrl;
    logic     br_take;
    logic     ldstall;
    logic     miss;

    // M has priority over W; the PC register always reads from the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic       rw_m,
        input logic [3:0] wa_m,
        input logic       rw_w,
        input logic [3:0] wa_w
    );
        if (ra == PC_REG) begin
            return FWD_RF;
        end
        if (rw_m && (wa_m == ra)) begin
            return FWD_M;
        end
        if (rw_w && (wa_w == ra)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign ldstall = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign miss    = MemAccessM && !mem_ready;

    // Next-state and stall/flush decode; priority is memory wait > branch > load-use.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        br_cnt_d   = br_cnt_q;
        mem_err_d  = mem_err_q;
        ctrl       = '0;
        br_take    = 1'b0;

        case (state_q)
            RUN: begin
                if (miss) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    ctrl.stall_m = 1'b1;
                    ctrl.flush_w = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = '0;
                end else if (BranchTakenE) begin
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                    br_take      = 1'b1;
                    if (BR_FLUSH_CYC != 0) begin
                        state_d  = BR_FLUSH;
                        br_cnt_d = '0;
                    end
                end else if (ldstall) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    // Stalls drop so the pipe advances, but the failed load is squashed.
                    ctrl.flush_w = 1'b1;
                    mem_err_d    = 1'b1;
                    state_d      = RUN;
                end else begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    ctrl.stall_m = 1'b1;
                    ctrl.flush_w = 1'b1;
                    wait_cnt_d   = wait_cnt_q + SEQ_CNT_W'(1);
                end
            end

            BR_FLUSH: begin
                ctrl.flush_d = 1'b1;
                if (BranchTakenE) begin
                    ctrl.flush_e = 1'b1;
                    br_take      = 1'b1;
                    br_cnt_d     = '0;
                end else if ((br_cnt_q + SEQ_CNT_W'(1)) == BR_CYC_C) begin
                    state_d = RUN;
                end else begin
                    br_cnt_d = br_cnt_q + SEQ_CNT_W'(1);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // Reset forces every control output low immediately, not just at the next edge.
        if (rst) begin
            ctrl    = '0;
            br_take = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            br_cnt_q   <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_cnt_q   <= br_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign StallF    = ctrl.stall_f;
    assign StallD    = ctrl.stall_d;
    assign StallE    = ctrl.stall_e;
    assign StallM    = ctrl.stall_m;
    assign FlushD    = ctrl.flush_d;
    assign FlushE    = ctrl.flush_e;
    assign FlushW    = ctrl.flush_w;
    assign ForwardAE = rst ? FWD_RF : fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardBE = rst ? FWD_RF : fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign mem_err   = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.stall_f),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_take),
        .q   (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed multi-cycle sequences,
// and random stimulus against a behavioural model, on two parameterisations.
module tb_pipeline_hazard_ctrl;

    localparam int NI = 2;

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, m2r, macc, mrdy, brt;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic [10:0] exp;
    } tv_t;

    logic       clk;
    logic       rst;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemAccessM, mem_ready, BranchTakenE;

    logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, err0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, fc0;
    logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, err1;
    logic [1:0]  fa1, fb1;
    logic [3:0]  sc1, fc1;

    pipeline_hazard_ctrl #(.BR_FLUSH_CYC(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM),
        .mem_ready(mem_ready), .BranchTakenE(BranchTakenE),
        .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0),
        .FlushD(fd0), .FlushE(fe0), .FlushW(fw0), .ForwardAE(fa0), .ForwardBE(fb0),
        .mem_err(err0), .stall_cycles(sc0), .flush_events(fc0)
    );

    pipeline_hazard_ctrl #(.BR_FLUSH_CYC(2), .MEM_TIMEOUT(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM),
        .mem_ready(mem_ready), .BranchTakenE(BranchTakenE),
        .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
        .FlushD(fd1), .FlushE(fe1), .FlushW(fw1), .ForwardAE(fa1), .ForwardBE(fb1),
        .mem_err(err1), .stall_cycles(sc1), .flush_events(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state per instance: waiting flag, cycles already waited, flush cycles left.
    int p_to[NI], p_cyc[NI], p_max[NI];
    int m_wait[NI], m_waited[NI], m_brl[NI], m_err[NI], m_sc[NI], m_fe[NI];
    int n_wait[NI], n_waited[NI], n_brl[NI], n_err_m[NI], n_sc[NI], n_fe[NI];

    logic [10:0] a_out[NI];
    logic [31:0] a_sc[NI], a_fe[NI], a_err[NI];

    tv_t tbl[13];
    in_t v;

    function automatic logic [10:0] pk(input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic [1:0] fa, input logic [1:0] fb);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb};
    endfunction

    function automatic in_t mk(input logic [3:0] ra1d, input logic [3:0] ra2d,
                               input logic [3:0] ra1e, input logic [3:0] ra2e,
                               input logic [3:0] wa3e, input logic [3:0] wa3m,
                               input logic [3:0] wa3w, input logic rwe, input logic rwm,
                               input logic rww, input logic m2r, input logic macc,
                               input logic mrdy);
        in_t r;
        r = '0;
        r.ra1d = ra1d; r.ra2d = ra2d; r.ra1e = ra1e; r.ra2e = ra2e;
        r.wa3e = wa3e; r.wa3m = wa3m; r.wa3w = wa3w;
        r.rwe = rwe; r.rwm = rwm; r.rww = rww; r.m2r = m2r; r.macc = macc; r.mrdy = mrdy;
        return r;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [3:0] re, input in_t x);
        if (re == 4'd15) return 2'b00;
        if (x.rwm && (x.wa3m == re)) return 2'b10;
        if (x.rww && (x.wa3w == re)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input in_t x);
        rst = x.rst;
        RA1D = x.ra1d; RA2D = x.ra2d; RA1E = x.ra1e; RA2E = x.ra2e;
        WA3E = x.wa3e; WA3M = x.wa3m; WA3W = x.wa3w;
        RegWriteE = x.rwe; RegWriteM = x.rwm; RegWriteW = x.rww;
        MemtoRegE = x.m2r; MemAccessM = x.macc; mem_ready = x.mrdy; BranchTakenE = x.brt;
    endtask

    // Reference behaviour for one cycle; outputs now, next model state in n_*.
    task automatic model_eval(input int k, input in_t x, output logic [10:0] e);
        logic sf, sd, se, sm, fd, fe, fw;
        bit   take, ld;
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0; take = 0;
        if (x.rst) begin
            m_wait[k] = 0; m_waited[k] = 0; m_brl[k] = 0; m_err[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
            n_wait[k] = 0; n_waited[k] = 0; n_brl[k] = 0; n_err_m[k] = 0; n_sc[k] = 0; n_fe[k] = 0;
            e = '0;
        end else begin
            n_wait[k] = m_wait[k]; n_waited[k] = m_waited[k]; n_brl[k] = m_brl[k];
            n_err_m[k] = m_err[k]; n_sc[k] = m_sc[k]; n_fe[k] = m_fe[k];
            ld = x.m2r && x.rwe && ((x.wa3e == x.ra1d) || (x.wa3e == x.ra2d));
            if (m_wait[k] != 0) begin
                if (x.mrdy) begin
                    n_wait[k] = 0;
                end else if (m_waited[k] == p_to[k]) begin
                    fw = 1; n_err_m[k] = 1; n_wait[k] = 0;
                end else begin
                    sf = 1; sd = 1; se = 1; sm = 1; fw = 1; n_waited[k] = m_waited[k] + 1;
                end
            end else if (m_brl[k] == 0 && x.macc && !x.mrdy) begin
                sf = 1; sd = 1; se = 1; sm = 1; fw = 1; n_wait[k] = 1; n_waited[k] = 0;
            end else if (x.brt) begin
                fd = 1; fe = 1; take = 1; n_brl[k] = p_cyc[k];
            end else if (m_brl[k] > 0) begin
                fd = 1; n_brl[k] = m_brl[k] - 1;
            end else if (ld) begin
                sf = 1; sd = 1; fe = 1;
            end
            if (sf && m_sc[k] < p_max[k]) n_sc[k] = m_sc[k] + 1;
            if (take && m_fe[k] < p_max[k]) n_fe[k] = m_fe[k] + 1;
            e = pk(sf, sd, se, sm, fd, fe, fw, ref_fwd(x.ra1e, x), ref_fwd(x.ra2e, x));
        end
    endtask

    task automatic step(input in_t x);
        logic [10:0] e;
        @(posedge clk);
        drive(x);
        #1;
        a_out[0] = {sf0, sd0, se0, sm0, fd0, fe0, fw0, fa0, fb0};
        a_out[1] = {sf1, sd1, se1, sm1, fd1, fe1, fw1, fa1, fb1};
        a_sc[0] = 32'(sc0); a_fe[0] = 32'(fc0); a_err[0] = 32'(err0);
        a_sc[1] = 32'(sc1); a_fe[1] = 32'(fc1); a_err[1] = 32'(err1);
        for (int k = 0; k < NI; k++) begin
            model_eval(k, x, e);
            chk($sformatf("model_outs[%0d]", k), 32'(a_out[k]), 32'(e));
            chk($sformatf("model_stall_cycles[%0d]", k), a_sc[k], 32'(m_sc[k]));
            chk($sformatf("model_flush_events[%0d]", k), a_fe[k], 32'(m_fe[k]));
            chk($sformatf("model_mem_err[%0d]", k), a_err[k], 32'(m_err[k]));
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            m_wait[k] = n_wait[k]; m_waited[k] = n_waited[k]; m_brl[k] = n_brl[k];
            m_err[k] = n_err_m[k]; m_sc[k] = n_sc[k]; m_fe[k] = n_fe[k];
        end
        cyc++;
    endtask

    task automatic do_reset();
        in_t r;
        r = '0;
        r.rst = 1'b1;
        step(r);
        for (int k = 0; k < NI; k++) chk("reset_outs", 32'(a_out[k]), 32'd0);
        r.rst = 1'b0;
        step(r);
    endtask

    localparam logic [10:0] E_STALL_ALL = 11'b111_1001_0000;
    localparam logic [10:0] E_LD        = 11'b110_0010_0000;
    localparam logic [10:0] E_BR        = 11'b000_0110_0000;
    localparam logic [10:0] E_FD        = 11'b000_0100_0000;
    localparam logic [10:0] E_FW        = 11'b000_0001_0000;

    initial begin
        p_to[0] = 255; p_cyc[0] = 1; p_max[0] = 65535;
        p_to[1] = 3;   p_cyc[1] = 2; p_max[1] = 15;
        for (int k = 0; k < NI; k++) begin
            m_wait[k] = 0; m_waited[k] = 0; m_brl[k] = 0; m_err[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
        end
        v = '0;
        v.rst = 1'b1;
        drive(v);

        tbl[0]  = '{mk(0,0,3,0, 0,3,3, 0,1,1,0,0,0),  pk(0,0,0,0,0,0,0,2'b10,2'b00)};
        tbl[1]  = '{mk(0,0,3,0, 0,3,3, 0,0,1,0,0,0),  pk(0,0,0,0,0,0,0,2'b01,2'b00)};
        tbl[2]  = '{mk(0,0,15,0, 0,15,15, 0,1,1,0,0,0), pk(0,0,0,0,0,0,0,2'b00,2'b00)};
        tbl[3]  = '{mk(0,0,2,7, 0,7,2, 0,1,1,0,0,0),  pk(0,0,0,0,0,0,0,2'b01,2'b10)};
        tbl[4]  = '{mk(0,0,4,4, 0,4,4, 0,1,0,0,0,0),  pk(0,0,0,0,0,0,0,2'b10,2'b10)};
        tbl[5]  = '{mk(0,0,1,15, 0,1,15, 0,1,1,0,0,0), pk(0,0,0,0,0,0,0,2'b10,2'b00)};
        tbl[6]  = '{mk(0,0,6,6, 0,6,6, 0,0,0,0,0,0),  pk(0,0,0,0,0,0,0,2'b00,2'b00)};
        tbl[7]  = '{mk(0,5,0,0, 5,0,0, 1,0,0,1,0,0),  E_LD};
        tbl[8]  = '{mk(9,0,0,0, 9,0,0, 1,0,0,1,0,0),  E_LD};
        tbl[9]  = '{mk(9,9,0,0, 9,0,0, 0,0,0,1,0,0),  11'd0};
        tbl[10] = '{mk(1,2,0,0, 9,0,0, 1,0,0,1,0,0),  11'd0};
        tbl[11] = '{mk(0,0,0,0, 0,0,0, 0,0,0,0,1,1),  11'd0};
        tbl[12] = '{mk(8,0,8,0, 8,8,0, 1,1,0,1,0,0),  pk(1,1,0,0,0,1,0,2'b10,2'b00)};

        // Single-cycle vectors from the RUN state.
        do_reset();
        for (int t = 0; t < 13; t++) begin
            step(tbl[t].i);
            chk($sformatf("tbl[%0d]_dut0", t), 32'(a_out[0]), 32'(tbl[t].exp));
            chk($sformatf("tbl[%0d]_dut1", t), 32'(a_out[1]), 32'(tbl[t].exp));
        end
        step('0);
        chk("tbl_stall_cycles", a_sc[0], 32'd3);

        // Load-use: exactly one bubble.
        do_reset();
        v = '0; v.m2r = 1; v.rwe = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
        step(v);
        chk("ld_use", 32'(a_out[0]), 32'(E_LD));
        step('0);
        chk("ld_use_released", 32'(a_out[0]), 32'd0);
        chk("ld_use_stall_cycles", a_sc[0], 32'd1);

        // Taken branch: flush D/E then D for BR_FLUSH_CYC more cycles.
        do_reset();
        v = '0; v.brt = 1;
        step(v);
        chk("br_dut0", 32'(a_out[0]), 32'(E_BR));
        chk("br_dut1", 32'(a_out[1]), 32'(E_BR));
        step('0);
        chk("br_tail1_dut0", 32'(a_out[0]), 32'(E_FD));
        chk("br_tail1_dut1", 32'(a_out[1]), 32'(E_FD));
        chk("br_flush_events", a_fe[0], 32'd1);
        step('0);
        chk("br_tail2_dut0", 32'(a_out[0]), 32'd0);
        chk("br_tail2_dut1", 32'(a_out[1]), 32'(E_FD));
        step('0);
        chk("br_done_dut1", 32'(a_out[1]), 32'd0);

        // Memory wait masks a pending branch and load-use; branch is taken after release.
        do_reset();
        v = '0; v.macc = 1; v.brt = 1; v.m2r = 1; v.rwe = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
        for (int c = 0; c < 4; c++) begin
            step(v);
            chk($sformatf("mw_stall%0d", c), 32'(a_out[0]), 32'(E_STALL_ALL));
        end
        v.mrdy = 1;
        step(v);
        chk("mw_release_dut0", 32'(a_out[0]), 32'd0);
        chk("mw_release_dut1", 32'(a_out[1]), 32'd0);
        v.macc = 0; v.mrdy = 0;
        step(v);
        chk("mw_branch_after", 32'(a_out[0]), 32'(E_BR));
        step('0);
        chk("mw_stall_cycles", a_sc[0], 32'd4);
        chk("mw_no_err", a_err[0], 32'd0);
        step('0);

        // Timeout on the MEM_TIMEOUT=3 instance.
        do_reset();
        v = '0; v.macc = 1;
        for (int c = 0; c < 4; c++) begin
            step(v);
            chk($sformatf("to_stall%0d", c), 32'(a_out[1]), 32'(E_STALL_ALL));
        end
        step(v);
        chk("to_release_flushw", 32'(a_out[1]), 32'(E_FW));
        for (int c = 0; c < 3; c++) begin
            step('0);
            chk($sformatf("to_err_sticky%0d", c), a_err[1], 32'd1);
            chk($sformatf("to_idle%0d", c), 32'(a_out[1]), 32'd0);
        end
        chk("to_stall_cycles", a_sc[1], 32'd4);

        // Reset while the default instance is still waiting on memory.
        chk("pre_rst_waiting", 32'(a_out[0]), 32'(E_STALL_ALL));
        v = '0; v.rst = 1; v.brt = 1; v.rwm = 1; v.wa3m = 4'd3; v.ra1e = 4'd3; v.macc = 1;
        step(v);
        chk("rst_outs_dut0", 32'(a_out[0]), 32'd0);
        chk("rst_outs_dut1", 32'(a_out[1]), 32'd0);
        chk("rst_err_dut1", a_err[1], 32'd0);
        chk("rst_sc_dut0", a_sc[0], 32'd0);
        step('0);
        chk("post_rst_outs", 32'(a_out[0]), 32'd0);
        chk("post_rst_err", a_err[0], 32'd0);

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            v.rst  = ($urandom_range(0, 63) == 0);
            v.ra1d = rreg(); v.ra2d = rreg(); v.ra1e = rreg(); v.ra2e = rreg();
            v.wa3e = rreg(); v.wa3m = rreg(); v.wa3w = rreg();
            v.rwe  = 1'($urandom_range(0, 1)); v.rwm = 1'($urandom_range(0, 1));
            v.rww  = 1'($urandom_range(0, 1)); v.m2r = 1'($urandom_range(0, 1));
            v.macc = ($urandom_range(0, 9) < 3);
            v.mrdy = ($urandom_range(0, 9) < 4);
            v.brt  = ($urandom_range(0, 9) < 2);
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage pipelined CPU. It drives stall, flush and forwarding for the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. It resolves register-read hazards by forwarding, load-use hazards by a one-cycle stall, taken branches by flushing younger stages, and slow data-memory accesses through a wait-state FSM with timeout. It also keeps saturating stall and flush statistics for debug.

## Interface
- BR_FLUSH_CYC, default 1: extra cycles FlushD stays asserted after a taken branch (0..3).
- MEM_TIMEOUT, default 255: maximum consecutive wait cycles before abort.
- CNT_W, default 16: width of the statistics counters.

- clk  in  1  pipeline clock; state updates on negedge, same edge as the segment registers
- rst  in  1  reset, asynchronous, active-high
- RA1D, RA2D  in  4  source registers in decode
- RA1E, RA2E  in  4  source registers in execute
- WA3E, WA3M, WA3W  in  4  destination registers in E, M and W
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage
- MemtoRegE  in  1  instruction in E is a load
- MemAccessM  in  1  M stage issues a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- BranchTakenE  in  1  branch resolved taken in E
- StallF, StallD, StallE, StallM  out  1  hold the corresponding register
- FlushD, FlushE, FlushW  out  1  load a bubble (all controls 0) into the register
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 from W, 10 from M
- mem_err  out  1  sticky; a memory access timed out
- stall_cycles, flush_events  out  CNT_W  statistics, saturating

## Operation
- Forwarding (combinational): ForwardAE=10 if RegWriteM && WA3M==RA1E; else 01 if RegWriteW && WA3W==RA1E; else 00. M has priority. ForwardBE is the same rule using RA2E.
- Register 15 (PC) is never forwarded. If RA1E or RA2E is 15, select 00.
- ldstall = MemtoRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D).
- FSM states:
  - RUN to MEM_WAIT when MemAccessM && !mem_ready.
  - RUN to BR_FLUSH when BranchTakenE and BR_FLUSH_CYC>0.
  - MEM_WAIT to RUN on mem_ready, or when wait_cnt reaches MEM_TIMEOUT. The timeout sets mem_err.
  - BR_FLUSH to RUN when br_cnt reaches BR_FLUSH_CYC.
- MEM_WAIT (and RUN with a miss pending):
  - StallF/D/E/M=1 and FlushW=1.
  - No other flush.
  - BranchTakenE is ignored, because the E instruction is frozen. It is re-evaluated after release.
- Branch (RUN with BranchTakenE):
  - FlushD=1 and FlushE=1.
  - BR_FLUSH keeps FlushD=1 for BR_FLUSH_CYC more cycles.
- Load-use (RUN, no miss, no branch): StallF=StallD=1 and FlushE=1.
- Priority: memory wait > taken branch > load-use.
- A taken branch in BR_FLUSH restarts br_cnt at 0.
- wait_cnt and br_cnt are 8-bit and clear on entering their state.
- stall_cycles increments on each negedge with StallF=1. flush_events increments on each taken branch accepted. Both saturate at all-ones.
- mem_err clears only on rst.

## Timing
- Stall, flush and forward outputs are combinational from the current state and inputs. They are valid before the negedge that samples them.
- Load-use costs exactly one bubble. A branch costs 2+BR_FLUSH_CYC bubbles.
- mem_ready high in the same cycle as the request causes zero stall.
- rst forces immediately: state RUN, all counters 0, mem_err 0, every stall/flush output 0, ForwardAE/BE 00.
- If rst asserts mid-MEM_WAIT, the FSM aborts to RUN without setting mem_err.
- At timeout (wait_cnt==MEM_TIMEOUT):
  - Stalls release on that cycle's edge.
  - FlushW stays 1 for that cycle, so the failed load never writes back.

## Structure
- The shared package hazard_pkg holds:
  - typedef hz_state_t {RUN, MEM_WAIT, BR_FLUSH};
  - forwarding select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - constant PC_REG=4'd15.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, q) is instantiated twice for the statistics.
- Forwarding is a small internal function. No separate module.

## Test plan
- WA3M=3 with RegWriteM=1, RA1E=3; also WA3W=3 with RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set RA1E=15 → 00.
- MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle only. stall_cycles=1.
- BranchTakenE=1 with BR_FLUSH_CYC=1 → FlushD=FlushE=1 in that cycle, then FlushD=1 for one more cycle. flush_events=1.
- MemAccessM=1, mem_ready low for 4 cycles, with BranchTakenE=1 and ldstall also present → F/D/E/M stalled and FlushW=1 for 4 cycles, no branch flush. Release on mem_ready, then the branch flush occurs.
- MEM_TIMEOUT=3, mem_ready held low → release after 4 stall cycles. mem_err=1 and stays set until rst.
- rst pulsed mid-MEM_WAIT → all outputs 0 at once, FSM in RUN, counters 0, mem_err 0.
